// File: rtl/_64b66b_tx_pkg.sv
// Shared constants for the 64b/66b self-synchronous scrambler (tx) and descrambler (rx).
package _64b66b_tx_pkg;

   // Taps of G(x)=1+x^39+x^58 expressed as s_q indices, and the state width.
   localparam int I0  = 38;
   localparam int I1  = 57;
   localparam int S_W = 58;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   typedef logic [S_W-1:0] scr_state_t;

   localparam scr_state_t SCR_SEED = {S_W{1'b1}};

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer (output register plus skid register) with a registered ready.
module skid_buf #(
   parameter int W = 66
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         ready_q, ready_d;
   logic         acc_s, drain_s;

   assign acc_s   = in_valid & ready_q;
   assign drain_s = ~out_valid_q | out_ready;

   // Next-state: refill the output stage from skid first, otherwise from the input.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (drain_s) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (acc_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         if (acc_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
      ready_d = ~skid_valid_d;
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/_64b66b_tx.sv
// 64b/66b transmit scrambler: LEN payload bits per beat through G(x)=1+x^39+x^58,
// header bypassed, result handed to a skid buffer.
module _64b66b_tx
   import _64b66b_tx_pkg::*;
#(
   parameter int LEN = 64
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [1:0]     head_i,
   input  logic [LEN-1:0] data_i,
   output logic           valid_o,
   input  logic           ready_i,
   output logic [1:0]     head_o,
   output logic [LEN-1:0] scram_o
);

   localparam int HW = S_W + LEN;

   scr_state_t     s_q, s_d;
   logic [LEN-1:0] scram_s;
   logic           accept_s;

   assign accept_s = valid_i & ready_o;

   // hist[j] is the stream in transmit order: s_q history (oldest first) followed by
   // this beat, so both taps of bit i land at hist[i] and hist[i+19].
   always_comb begin
      logic [HW-1:0] hist;
      hist = '0;
      for (int j = 0; j < S_W; j++) begin
         hist[j] = s_q[S_W-1-j];
      end
      for (int i = 0; i < LEN; i++) begin
         hist[S_W+i] = data_i[i] ^ hist[i+(I1-I0)] ^ hist[i];
      end
      scram_s = hist[S_W +: LEN];
      s_d     = s_q;
      if (accept_s) begin
         for (int k = 0; k < S_W; k++) begin
            s_d[k] = hist[HW-1-k];
         end
      end else begin
         s_d = s_q;
      end
   end

   // Scrambler history register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s_q <= SCR_SEED;
      end else begin
         s_q <= s_d;
      end
   end

   skid_buf #(
      .W(LEN + 2)
   ) u_skid (
      .clk      (clk),
      .nreset   (nreset),
      .in_valid (valid_i),
      .in_ready (ready_o),
      .in_data  ({head_i, scram_s}),
      .out_valid(valid_o),
      .out_ready(ready_i),
      .out_data ({head_o, scram_o})
   );

endmodule

// File: tb/tb__64b66b_tx.sv
// Directed/table bench for _64b66b_tx: bit-serial scrambler and descrambler models as reference.
module tb__64b66b_tx;
   import _64b66b_tx_pkg::*;

   localparam int LEN = 64;
   localparam logic [LEN-1:0] ZERO_SCR = 64'h03FF_FF80_0000_0000;

   logic           clk = 1'b0;
   logic           nreset = 1'b1;
   logic           valid_i = 1'b0;
   logic           ready_i = 1'b0;
   logic [1:0]     head_i = 2'b00;
   logic [LEN-1:0] data_i = '0;
   logic           ready_o, valid_o;
   logic [1:0]     head_o;
   logic [LEN-1:0] scram_o;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   _64b66b_tx #(.LEN(LEN)) dut (
      .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
      .head_i(head_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
      .head_o(head_o), .scram_o(scram_o)
   );

   typedef struct packed {
      logic [1:0]     h;
      logic [LEN-1:0] s;
      logic [LEN-1:0] d;
   } beat_t;

   typedef struct {
      logic           v, r;
      logic [1:0]     h;
      logic [LEN-1:0] d;
      logic           ev, er;
      logic [1:0]     eh;
      logic           cs;
   } vec_t;

   logic [57:0] tx_m = {58{1'b1}};
   logic [57:0] rx_m = {58{1'b1}};
   beat_t       expq[$];
   vec_t        tbl[11];

   task automatic check(input string name, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tx_scr(input logic [LEN-1:0] d, output logic [LEN-1:0] s);
      for (int i = 0; i < LEN; i++) begin
         s[i] = d[i] ^ tx_m[38] ^ tx_m[57];
         tx_m = {tx_m[56:0], s[i]};
      end
   endtask

   task automatic rx_descr(input logic [LEN-1:0] s, output logic [LEN-1:0] d);
      for (int i = 0; i < LEN; i++) begin
         d[i] = s[i] ^ rx_m[38] ^ rx_m[57];
         rx_m = {rx_m[56:0], s[i]};
      end
   endtask

   task automatic step(input logic v, input logic r, input logic [1:0] h, input logic [LEN-1:0] d);
      logic [LEN-1:0] s, rd;
      beat_t          b;
      valid_i = v; ready_i = r; head_i = h; data_i = d;
      if (v && ready_o) begin
         tx_scr(d, s);
         expq.push_back('{h, s, d});
      end
      if (valid_o && r) begin
         if (expq.size() == 0) begin
            tests++; failed++;
            $display("FAIL extra_beat: got beat %h expected none", scram_o);
         end else begin
            b = expq.pop_front();
            check("head_o", {62'd0, head_o}, {62'd0, b.h});
            check("scram_o", scram_o, b.s);
            rx_descr(scram_o, rd);
            check("loopback", rd, b.d);
         end
      end
      @(posedge clk); #1;
      check("s_q", {6'd0, dut.s_q}, {6'd0, tx_m});
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      #1;
      check("rst valid_o", {63'd0, valid_o}, 64'd0);
      check("rst ready_o", {63'd0, ready_o}, 64'd1);
      check("rst s_q", {6'd0, dut.s_q}, {6'd0, {58{1'b1}}});
      check("rst head_o", {62'd0, head_o}, 64'd0);
      check("rst scram_o", scram_o, 64'd0);
      tx_m = {58{1'b1}};
      rx_m = {58{1'b1}};
      expq.delete();
      valid_i = 1'b0; ready_i = 1'b0;
      #2;
      nreset = 1'b1;
      @(posedge clk); #1;
      check("post-rst ready_o", {63'd0, ready_o}, 64'd1);
      check("post-rst valid_o", {63'd0, valid_o}, 64'd0);
   endtask

   task automatic drain();
      for (int c = 0; c < 10 && expq.size() > 0; c++) step(1'b0, 1'b1, 2'b00, '0);
      check("drained", 64'(expq.size()), 64'd0);
   endtask

   initial begin
      int sent;
      logic acc;
      //              v     r     h          d                     ev    er    eh         cs
      tbl[0]  = '{1'b1, 1'b0, SYNC_DATA, 64'd0,                 1'b1, 1'b1, SYNC_DATA, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, SYNC_CTRL, 64'hA5A5_5A5A_F00F_1234, 1'b1, 1'b0, SYNC_DATA, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, SYNC_DATA, 64'hDEAD_BEEF_0BAD_CAFE, 1'b1, 1'b0, SYNC_DATA, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, SYNC_DATA, 64'hDEAD_BEEF_0BAD_CAFE, 1'b1, 1'b0, SYNC_DATA, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, SYNC_DATA, 64'hDEAD_BEEF_0BAD_CAFE, 1'b1, 1'b0, SYNC_DATA, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 2'b00,     64'd0,                 1'b1, 1'b1, SYNC_CTRL, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 2'b11,     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 2'b11,     1'b0};
      tbl[7]  = '{1'b0, 1'b1, 2'b00,     64'd0,                 1'b0, 1'b1, 2'b00,     1'b0};
      tbl[8]  = '{1'b0, 1'b0, 2'b00,     64'd0,                 1'b0, 1'b1, 2'b00,     1'b0};
      tbl[9]  = '{1'b1, 1'b1, 2'b00,     64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 2'b00,     1'b0};
      tbl[10] = '{1'b0, 1'b1, 2'b00,     64'd0,                 1'b0, 1'b1, 2'b00,     1'b0};

      #1;
      do_reset();

      for (int k = 0; k < 11; k++) begin
         step(tbl[k].v, tbl[k].r, tbl[k].h, tbl[k].d);
         check($sformatf("row%0d valid_o", k), {63'd0, valid_o}, {63'd0, tbl[k].ev});
         check($sformatf("row%0d ready_o", k), {63'd0, ready_o}, {63'd0, tbl[k].er});
         if (tbl[k].ev) check($sformatf("row%0d head_o", k), {62'd0, head_o}, {62'd0, tbl[k].eh});
         if (tbl[k].cs) check($sformatf("row%0d zero beat", k), scram_o, ZERO_SCR);
      end

      // Fill output and skid, then reset asynchronously mid-stream.
      step(1'b1, 1'b0, SYNC_CTRL, 64'h1111_2222_3333_4444);
      step(1'b1, 1'b0, SYNC_DATA, 64'h5555_6666_7777_8888);
      check("skid full ready_o", {63'd0, ready_o}, 64'd0);
      do_reset();
      step(1'b1, 1'b0, SYNC_DATA, 64'd0);
      check("post-rst zero beat", scram_o, ZERO_SCR);
      check("post-rst head", {62'd0, head_o}, {62'd0, SYNC_DATA});
      check("post-rst beat valid", {63'd0, valid_o}, 64'd1);
      drain();

      // ready_i toggling every cycle, valid_i held high.
      sent = 0;
      for (int c = 0; c < 2000 && sent < 300; c++) begin
         acc = ready_o;
         step(1'b1, c[0], 2'($urandom_range(0, 3)), {$urandom(), $urandom()});
         if (acc) sent++;
      end
      check("toggle beats sent", 64'(sent), 64'd300);
      drain();

      // Random valid/ready.
      sent = 0;
      for (int c = 0; c < 4000 && sent < 300; c++) begin
         acc = ready_o;
         valid_i = 1'($urandom_range(0, 1));
         step(valid_i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {$urandom(), $urandom()});
         if (acc && valid_i) sent++;
      end
      check("random beats sent", 64'(sent), 64'd300);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/_64b66b_tx.md
_64B66B_TX -- requirements
Module: _64b66b_tx

Interface
REQ-001 Parameter LEN, default 64: scrambled payload bits per accepted beat, LEN >= 1.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  upstream beat present.
REQ-005 ready_o  output  1  block can accept a beat this cycle.
REQ-006 head_i  input  2  sync header of the beat, carried unscrambled.
REQ-007 data_i  input  LEN  plain payload; bit 0 is transmitted first.
REQ-008 valid_o  output  1  downstream beat present.
REQ-009 ready_i  input  1  downstream accepts the beat this cycle.
REQ-010 head_o  output  2  header of the output beat, equal to the accepted head_i.
REQ-011 scram_o  output  LEN  scrambled payload of the output beat.

Function
REQ-012 The block SHALL scramble self-synchronously with G(x)=1+x^39+x^58: s[n] = d[n] ^ s[n-39] ^ s[n-58], where s is the scrambled bit stream in transmit order.
REQ-013 The state register s_q (58 bits) SHALL hold the last 58 scrambled bits sent: s_q[k] = scrambled bit k+1 positions before the current beat's bit 0.
REQ-014 Bit i of a beat SHALL use s_q for history terms older than the current beat and the current beat's own scrambled bits otherwise: i<=38 uses s_q[38-i], s_q[57-i]; 39<=i<=57 uses scram[i-39], s_q[57-i]; i>=58 uses scram[i-39], scram[i-58].
REQ-015 On acceptance (valid_i & ready_o), s_q SHALL load s_q[k]=scram[LEN-1-k] for k<LEN, and shift s_q[k]=s_q[k-LEN] for k>=LEN.
REQ-016 s_q SHALL NOT change on any cycle without acceptance, including stalls.
REQ-017 head_i SHALL bypass the scrambler and SHALL NOT enter s_q.
REQ-018 Latency: a beat accepted at edge N SHALL be presented on valid_o/head_o/scram_o from edge N onward (one register stage).
REQ-019 Output handshake: the beat SHALL stay stable on head_o/scram_o with valid_o high until a cycle with ready_i high.
REQ-020 Buffering: an output register plus a one-entry skid register; ready_o = NOT skid_valid, registered (no combinational path from ready_i to ready_o).
REQ-021 Output full, ready_i low, beat accepted: the beat SHALL go to the skid register; ready_o SHALL drop next cycle.
REQ-022 Output drained with skid full: skid contents SHALL move to the output register on the same edge; ready_o SHALL rise next cycle.
REQ-023 Simultaneous drain and accept with skid empty: the new beat SHALL replace the output register directly.
REQ-024 Beat order SHALL be preserved; no beat dropped or duplicated.
REQ-025 valid_o, head_o, scram_o SHALL be independent of data_i/head_i within a cycle (fully registered).

Reset
REQ-026 Asserting nreset SHALL immediately force s_q to all ones, valid_o and skid_valid to 0, ready_o to 1, head_o to 0 and scram_o to 0, regardless of the clock.
REQ-027 Reset mid-stream SHALL discard buffered beats; the first beat after deassertion SHALL scramble from the all-ones state.
REQ-028 ready_o SHALL be 1 in the first cycle after deassertion.

Structure
REQ-029 A shared package SHALL hold the tap constants (I0=38, I1=57, S_W=58) and the sync header constants (SYNC_DATA=2'b01, SYNC_CTRL=2'b10), shared with the rx descrambler.
REQ-030 The handshake buffer SHALL be one sub-module, skid_buf, parameterized on width (LEN+2); the scrambler datapath and s_q SHALL live in _64b66b_tx.

Verification
REQ-031 After reset, accept one beat with data_i=0, head_i=2'b01 -> scram_o bits 0..38 = 0, bits 39..57 = 1, head_o=2'b01 one cycle later.
REQ-032 Loopback: 1000 random beats into _64b66b_tx, scram_o into the rx descrambler (both starting all ones) -> recovered data equals data_i for every beat; repeat with LEN=32 and LEN=66.
REQ-033 Hold ready_i low for 5 cycles with valid_i high -> exactly 2 beats held, ready_o low from the third cycle, s_q unchanged while stalled, output order intact after release.
REQ-034 Pulse nreset low mid-stream with the skid full -> valid_o=0, ready_o=1, s_q all ones immediately; the next beat matches REQ-031.
REQ-035 ready_i toggling every cycle with valid_i always high -> zero lost or duplicated beats; scrambled stream identical to the unstalled run.
